// File: rtl/debounce_scheduler.sv
// Debounces N_KEYS raw key inputs using one shared delay counter.
// A round-robin arbiter grants the counter to one key at a time.
//   state    | meaning
//   ST_IDLE  | no key granted; arbitrate among pending keys
//   ST_WAIT  | counting DELAY cycles; a level change on the key aborts
//   ST_CHECK | one-cycle re-check; commit stable level and press pulse
module debounce_scheduler #(
    parameter int N_KEYS = 4,
    parameter int DELAY  = 1_500_000,
    parameter int CNT_W  = 21,
    parameter int IDX_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic [N_KEYS-1:0] i_sw,
    output logic [N_KEYS-1:0] o_stable,
    output logic [N_KEYS-1:0] o_one_shot,
    output logic              o_busy,
    output logic [IDX_W-1:0]  o_active_key
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_CHECK = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [N_KEYS-1:0]   r_sync1;
    logic [N_KEYS-1:0]   r_sync2;
    logic [N_KEYS-1:0]   r_stable;
    logic [N_KEYS-1:0]   r_one_shot;
    logic [IDX_W-1:0]    r_idx;
    logic [IDX_W-1:0]    r_rr_ptr;
    logic [CNT_W-1:0]    r_cnt;
    logic                r_sample;

    logic [N_KEYS-1:0]   w_pending;
    logic                w_found;
    logic [IDX_W-1:0]    w_grant_idx;
    logic [IDX_W-1:0]    w_cand;
    logic                w_sw_cur;
    logic                w_glitch;
    logic                w_cnt_tc;
    logic [IDX_W-1:0]    w_next_ptr;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= i_sw;
            r_sync2 <= r_sync1;
        end
    end

    // A request is a level difference, so a key that returns to its stable level drops out
    assign w_pending  = r_sync2 ^ r_stable;
    assign w_sw_cur   = r_sync2[r_idx];
    assign w_glitch   = (w_sw_cur != r_sample);
    assign w_cnt_tc   = (r_cnt == CNT_W'(DELAY - 1));
    assign w_next_ptr = (r_idx == IDX_W'(N_KEYS - 1)) ? '0 : r_idx + IDX_W'(1);

    always_comb begin
        w_found     = 1'b0;
        w_grant_idx = '0;
        w_cand      = '0;
        for (int off = 0; off < N_KEYS; off++) begin
            w_cand = IDX_W'((int'(r_rr_ptr) + off) % N_KEYS);
            if (!w_found && w_pending[w_cand]) begin
                w_found     = 1'b1;
                w_grant_idx = w_cand;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (w_glitch) begin
                    w_state_nxt = ST_IDLE;
                end else if (w_cnt_tc) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_idx      <= '0;
            r_rr_ptr   <= '0;
            r_cnt      <= '0;
            r_sample   <= 1'b0;
            r_stable   <= '0;
            r_one_shot <= '0;
        end else begin
            r_one_shot <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_idx    <= w_grant_idx;
                        r_sample <= r_sync2[w_grant_idx];
                        r_cnt    <= '0;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt + CNT_W'(1);
                    // Aborted keys also advance the pointer so a bouncing key cannot starve others
                    if (w_glitch) begin
                        r_rr_ptr <= w_next_ptr;
                    end
                end
                ST_CHECK: begin
                    if (!w_glitch) begin
                        r_stable[r_idx] <= r_sample;
                        if (r_sample) begin
                            r_one_shot[r_idx] <= 1'b1;
                        end
                    end
                    r_rr_ptr <= w_next_ptr;
                end
                default: begin
                    r_cnt <= '0;
                end
            endcase
        end
    end

    assign o_stable     = r_stable;
    assign o_one_shot   = r_one_shot;
    assign o_busy       = (r_state != ST_IDLE);
    assign o_active_key = r_idx;

endmodule

// File: tb/tb_debounce_scheduler.sv
// Scoreboard bench for debounce_scheduler: a time-window reference model predicts
// stable/one_shot events into a queue that a negedge monitor pops and compares.
module tb_debounce_scheduler;

    localparam int N   = 4;
    localparam int DLY = 8;
    localparam int CW  = 4;
    localparam int IW  = 2;

    typedef struct {
        int         e;
        logic [N-1:0] st;
        logic [N-1:0] os;
    } ev_t;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [N-1:0]  sw = '0;
    logic [N-1:0]  o_stable;
    logic [N-1:0]  o_one_shot;
    logic          o_busy;
    logic [IW-1:0] o_active_key;

    int checks   = 0;
    int failures = 0;
    int n_events = 0;
    int cyc      = 0;

    ev_t q[$];

    debounce_scheduler #(
        .N_KEYS(N),
        .DELAY (DLY),
        .CNT_W (CW),
        .IDX_W (IW)
    ) dut (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_sw        (sw),
        .o_stable    (o_stable),
        .o_one_shot  (o_one_shot),
        .o_busy      (o_busy),
        .o_active_key(o_active_key)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Reference model: a granted key must hold its sampled synchronized level for the
    // DELAY edges after the grant edge and again on the following edge to be committed.
    logic [N-1:0]  m_s1, m_s2, m_stable;
    logic          m_busy;
    logic [IW-1:0] m_idx;
    int            m_rr;
    int            m_g;
    logic          m_sample;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_s1 = '0; m_s2 = '0; m_stable = '0;
            m_busy = 1'b0; m_idx = '0; m_rr = 0; m_g = 0; m_sample = 1'b0;
            q.delete();
        end else begin
            logic [N-1:0] ss;
            logic [N-1:0] pend;
            cyc++;
            ss = m_s2;
            if (!m_busy) begin
                pend = ss ^ m_stable;
                for (int off = 0; off < N; off++) begin
                    int k;
                    k = (m_rr + off) % N;
                    if (!m_busy && pend[k]) begin
                        m_busy   = 1'b1;
                        m_idx    = IW'(k);
                        m_sample = ss[k];
                        m_g      = cyc;
                    end
                end
            end else if (cyc <= m_g + DLY) begin
                if (ss[m_idx] != m_sample) begin
                    m_busy = 1'b0;
                    m_rr   = (int'(m_idx) + 1) % N;
                end
            end else begin
                if (ss[m_idx] == m_sample) begin
                    ev_t ev;
                    m_stable[m_idx] = m_sample;
                    ev.e  = cyc;
                    ev.st = m_stable;
                    ev.os = m_sample ? (N'(1) << m_idx) : '0;
                    q.push_back(ev);
                end
                m_busy = 1'b0;
                m_rr   = (int'(m_idx) + 1) % N;
            end
            m_s2 = m_s1;
            m_s1 = sw;
        end
    end

    logic [N-1:0] mon_prev = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("reset_outputs", {o_stable, o_one_shot, o_busy, o_active_key}, '0);
            mon_prev = '0;
        end else begin
            chk("busy", o_busy, m_busy);
            chk("active_key", o_active_key, m_idx);
            if (o_stable !== mon_prev || o_one_shot !== '0) begin
                if (q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_event: stable=%b one_shot=%b none expected at cycle %0d",
                             o_stable, o_one_shot, cyc);
                end else begin
                    ev_t ev;
                    ev = q.pop_front();
                    n_events++;
                    chk("event_cycle", ev.e, cyc);
                    chk("event_stable", o_stable, ev.st);
                    chk("event_one_shot", o_one_shot, ev.os);
                end
            end
            if (q.size() != 0 && q[0].e <= cyc) begin
                checks++;
                failures++;
                $display("FAIL missed_event: stable=%b one_shot=%b expected stable=%b one_shot=%b at cycle %0d",
                         o_stable, o_one_shot, q[0].st, q[0].os, q[0].e);
                void'(q.pop_front());
            end
            mon_prev = o_stable;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int k;
        tick(3);
        rst_n = 1'b1;

        // Idle with all keys low
        tick(50);
        chk("idle_stable", o_stable, '0);

        // Clean press and release on key 2
        sw[2] = 1'b1;
        tick(20);
        chk("key2_pressed", o_stable, 4'b0100);
        sw[2] = 1'b0;
        tick(20);
        chk("key2_released", o_stable, 4'b0000);

        // Bounce on key 1 shortly after grant, then held high
        sw[1] = 1'b1;
        tick(5);
        sw[1] = 1'b0;
        tick(3);
        sw[1] = 1'b1;
        tick(30);
        chk("key1_after_bounce", o_stable, 4'b0010);
        sw[1] = 1'b0;
        tick(20);

        // Simultaneous presses on keys 0 and 3
        sw[0] = 1'b1;
        sw[3] = 1'b1;
        tick(40);
        chk("keys03_pressed", o_stable, 4'b1001);
        sw = '0;
        tick(40);

        // Key 1 chattering continuously while key 2 is held
        sw[2] = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick(3);
            sw[1] = ~sw[1];
        end
        chk("key2_not_starved", o_stable[2], 1'b1);
        chk("key1_never_stable", o_stable[1], 1'b0);
        sw = '0;
        tick(40);

        // Reset in the middle of a debounce window
        sw[0] = 1'b1;
        tick(6);
        chk("busy_before_reset", o_busy, 1'b1);
        #2 rst_n = 1'b0;
        #1 chk("async_reset", {o_stable, o_one_shot, o_busy, o_active_key}, '0);
        tick(2);
        rst_n = 1'b1;
        tick(30);
        chk("key0_after_reset", o_stable, 4'b0001);
        sw = '0;
        tick(30);

        // Random activity: slow changes then heavy chatter
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 19) == 0) begin
                k = $urandom_range(0, N - 1);
                sw[k] = ~sw[k];
            end
        end
        for (int i = 0; i < 800; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 3) == 0) begin
                k = $urandom_range(0, N - 1);
                sw[k] = ~sw[k];
            end
        end
        tick(80);
        chk("settled_stable", o_stable, sw);
        chk("queue_drained", q.size(), 0);
        chk("events_seen", (n_events > 10) ? 1 : 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/debounce_scheduler.md
Name: debounce_scheduler

Overview:
- Debounces N_KEYS raw switch/key inputs using one shared delay counter instead of one delayer per key.
- Keys whose synchronized level differs from their debounced level request the timer. A round-robin arbiter grants one key at a time.
- After DELAY cycles the key is re-checked. A confirmed change updates the debounced level, and a press (0->1) emits a one-cycle one_shot.
- Sits between board keys/switches and the keyboard/UART and counter logic.

Parameters:
- N_KEYS, 4, number of key inputs (2..16).
- DELAY, 1_500_000, debounce window in clk cycles (30 ms at 50 MHz); must be >= 2.
- CNT_W, 21, shared counter width; must satisfy 2^CNT_W > DELAY.
- IDX_W, 2, width of active_key; equals ceil(log2(N_KEYS)), minimum 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-low reset.
- sw  in  N_KEYS  raw asynchronous key levels.
- stable  out  N_KEYS  debounced key levels.
- one_shot  out  N_KEYS  one-cycle pulse per confirmed press.
- busy  out  1  shared timer in use (state WAIT or CHECK).
- active_key  out  IDX_W  index of the key currently granted the timer.

Behaviour:
Reset:
- rst=0 asynchronously clears sync flops, stable, one_shot, busy, active_key, rr_ptr, counter, sample. State goes to IDLE.
- Release is used synchronously.

Input conditioning and requests:
- Each sw bit passes through a 2-flop synchronizer giving sw_s.
- pending[i] = sw_s[i] XOR stable[i].

FSM states: IDLE, WAIT, CHECK.

IDLE:
- If any pending bit is set, grant the first pending index at or after rr_ptr, searching circularly.
- Latch idx, active_key=idx, sample=sw_s[idx]. Clear the counter. Go to WAIT.
- busy is 1 from the next cycle.
- No pending bits: stay in IDLE, busy=0.

WAIT:
- Counter increments every cycle.
- If sw_s[idx] != sample, abort (glitch):
  - go to IDLE;
  - stable unchanged, no pulse;
  - rr_ptr = (idx+1) mod N_KEYS.
- Else if counter == DELAY-1, go to CHECK.

CHECK (one cycle):
- If sw_s[idx] == sample, set stable[idx] = sample. If sample==1, one_shot[idx]=1 for exactly one cycle (registered).
- If sw_s[idx] != sample, stable is unchanged and there is no pulse.
- In both cases rr_ptr = (idx+1) mod N_KEYS, then go to IDLE.

Outputs and timing:
- one_shot is 0 in every other cycle. At most one bit of one_shot is set at a time.
- Releases (1->0) update stable but never pulse.
- Latency with an idle scheduler: a clean sw edge sampled at clk edge k sets stable and one_shot at edge k+DELAY+3.
  - Edges 1-2: synchronizer.
  - Edge 3: grant.
  - DELAY edges: WAIT.
  - Then CHECK.
- active_key holds the last granted index while IDLE.

Arbitration:
- Pending keys not granted wait with no loss; their request is the level difference, not a stored event.
- Changes on other keys during a WAIT are not affected.
- A key that toggles and returns to its stable level before being granted is silently dropped, because pending clears.
- Simultaneous requests are served in circular order starting from rr_ptr. rr_ptr advances past every granted key, including aborted ones, so a bouncing key cannot starve the others.

Counter:
- Unsigned, CNT_W bits.
- Cleared on grant; only increments in WAIT.
- Never reaches wrap-around, since DELAY-1 < 2^CNT_W.

Reset mid-operation:
- Any in-flight WAIT/CHECK is discarded.
- stable returns to 0. No pulse is emitted for keys held high through reset until the full debounce completes again after release of rst.

Test Plan:
- DELAY=8, N_KEYS=4: after reset, hold sw=0000 for 50 cycles -> stable=0000, one_shot=0, busy=0, active_key=0 throughout.
- DELAY=8: sw[2] 0->1 clean, sampled at edge k -> stable[2]=1 and one_shot=0100 for exactly one cycle at edge k+11; busy high edges k+3..k+11. Then sw[2] 1->0 -> stable[2]=0 at the same latency, with no one_shot.
- DELAY=8: sw[1] goes high, then low again 3 cycles after grant (bounce) -> abort, stable[1]=0, no pulse, rr_ptr=2. sw[1] then held high -> re-granted and confirmed 11 edges after its new sample.
- DELAY=8: sw[0], sw[3] rise on the same edge, rr_ptr=0 -> key 0 pulses at edge k+11; key 3 granted next in IDLE, pulses 10 cycles later. Pulses never overlap.
- DELAY=8: key 1 toggling every 3 cycles continuously while sw[2] is held high -> key 2 is granted within one abort of key 1 and pulses. Key 1 never changes stable.
- DELAY=8: assert rst=0 mid-WAIT with sw[0]=1 -> all outputs 0 immediately (asynchronous). After rst=1, key 0 completes the full debounce again and pulses once.
